// File: rtl/jt053246_pkg.sv
// Shared types for the 053246 draw-command queue: command layout, dispatcher states, field widths.
package jt053246_pkg;

    localparam int CODE_W  = 16;
    localparam int ATTR_W  = 10;
    localparam int HPOS_W  = 9;
    localparam int YSUB_W  = 4;
    localparam int HZOOM_W = 12;
    localparam int SHD_W   = 2;
    localparam int CMD_W   = CODE_W + ATTR_W + 2 + HPOS_W + YSUB_W + HZOOM_W + 1 + SHD_W;

    typedef struct packed {
        logic [CODE_W-1:0]  code;
        logic [ATTR_W-1:0]  attr;
        logic               hflip;
        logic               vflip;
        logic [HPOS_W-1:0]  hpos;
        logic [YSUB_W-1:0]  ysub;
        logic [HZOOM_W-1:0] hzoom;
        logic               hz_keep;
        logic [SHD_W-1:0]   shd;
    } drawcmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } dq_state_t;

endpackage

// File: rtl/jt053246_drawq_if.sv
// Scanner-push and drawer-dispatch signals of the draw queue; slave is the queue side.
interface jt053246_drawq_if;
    import jt053246_pkg::*;

    logic               in_start;
    logic [CODE_W-1:0]  in_code;
    logic [ATTR_W-1:0]  in_attr;
    logic               in_hflip;
    logic               in_vflip;
    logic [HPOS_W-1:0]  in_hpos;
    logic [YSUB_W-1:0]  in_ysub;
    logic [HZOOM_W-1:0] in_hzoom;
    logic               in_hz_keep;
    logic [SHD_W-1:0]   in_shd;
    logic               in_busy;

    logic               dr_start;
    logic               dr_busy;
    logic [CODE_W-1:0]  code;
    logic [ATTR_W-1:0]  attr;
    logic               hflip;
    logic               vflip;
    logic [HPOS_W-1:0]  hpos;
    logic [YSUB_W-1:0]  ysub;
    logic [HZOOM_W-1:0] hzoom;
    logic               hz_keep;
    logic [SHD_W-1:0]   shd;

    modport master (
        output in_start, in_code, in_attr, in_hflip, in_vflip, in_hpos,
               in_ysub, in_hzoom, in_hz_keep, in_shd, dr_busy,
        input  in_busy, dr_start, code, attr, hflip, vflip, hpos, ysub,
               hzoom, hz_keep, shd
    );

    modport slave (
        input  in_start, in_code, in_attr, in_hflip, in_vflip, in_hpos,
               in_ysub, in_hzoom, in_hz_keep, in_shd, dr_busy,
        output in_busy, dr_start, code, attr, hflip, vflip, hpos, ysub,
               hzoom, hz_keep, shd
    );

endinterface

// File: rtl/jt053246_drawq_fifo.sv
// Register-array command FIFO with flush; pop loads dout one clock later (registered read).
// No internal backpressure: caller must not push when full or pop when empty.
module jt053246_drawq_fifo
    import jt053246_pkg::*;
#(
    parameter int AW = 3
)(
    input  logic     rst,
    input  logic     clk,
    input  logic     push,
    input  drawcmd_t din,
    input  logic     pop,
    input  logic     flush,
    output logic [AW:0] level,
    output drawcmd_t dout
);
    localparam int DEPTH = 1 << AW;

    drawcmd_t        mem_q [DEPTH];
    drawcmd_t        mem_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     level_q, level_d;
    drawcmd_t        dout_q, dout_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        dout_d  = dout_q;
        if (pop) begin
            dout_d = mem_q[rptr_q];
        end
        // Flush drops queued entries only; dout keeps the command already handed out.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            dout_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            dout_q  <= dout_d;
        end
    end

    assign level = level_q;
    assign dout  = dout_q;

endmodule

// File: rtl/jt053246_drawq.sv
// Draw-command queue between object scanner and line drawer; dispatch starts one cen cycle after a pop.
// in_busy (queue full) throttles the scanner; dr_busy holds off dispatch; hs flushes, vs clears loss counters.
module jt053246_drawq
    import jt053246_pkg::*;
#(
    parameter int AW     = 3,
    parameter int ACK_TO = 4
)(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        hs,
    input  logic        vs,
    jt053246_drawq_if.slave bus,
    output logic [AW:0] level,
    output logic [7:0]  drops,
    output logic        lost
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(ACK_TO + 1);

    dq_state_t     state_q, state_d;
    logic          dr_start_q, dr_start_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          hs_l_q, hs_l_d;
    logic          vs_l_q, vs_l_d;
    logic [7:0]    drops_q, drops_d;
    logic          lost_q, lost_d;

    logic          flush, vs_clr, full, push, ovf, pop;
    logic [AW:0]   loss_n;
    logic [8:0]    drops_sum;
    drawcmd_t      in_cmd, out_cmd;

    assign flush  = cen & hs & ~hs_l_q;
    assign vs_clr = cen & vs & ~vs_l_q;
    assign full   = (level == (AW+1)'(DEPTH));
    assign push   = cen & bus.in_start & ~full & ~flush;
    assign ovf    = cen & bus.in_start &  full & ~flush;

    assign in_cmd = {bus.in_code, bus.in_attr, bus.in_hflip, bus.in_vflip, bus.in_hpos,
                     bus.in_ysub, bus.in_hzoom, bus.in_hz_keep, bus.in_shd};

    jt053246_drawq_fifo #(.AW(AW)) u_fifo (
        .rst   (rst),
        .clk   (clk),
        .push  (push),
        .din   (in_cmd),
        .pop   (pop),
        .flush (flush),
        .level (level),
        .dout  (out_cmd)
    );

    always_comb begin
        state_d    = state_q;
        dr_start_d = dr_start_q;
        tmo_d      = tmo_q;
        pop        = 1'b0;
        if (cen) begin
            case (state_q)
                IDLE: if (level != '0 && !bus.dr_busy && !flush) begin
                    pop        = 1'b1;
                    dr_start_d = 1'b1;
                    state_d    = START;
                end
                START: begin
                    dr_start_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = ACK;
                end
                // A drawer that never raises busy has rejected or finished instantly.
                ACK: if (bus.dr_busy) begin
                    state_d = DONE;
                end else if (tmo_q == TW'(ACK_TO - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                DONE: if (!bus.dr_busy) begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hs_l_d  = cen ? hs : hs_l_q;
        vs_l_d  = cen ? vs : vs_l_q;
        drops_d = drops_q;
        lost_d  = lost_q;
        if (flush) begin
            loss_n = level;
        end else if (ovf) begin
            loss_n = (AW+1)'(1);
        end else begin
            loss_n = '0;
        end
        drops_sum = {1'b0, drops_q} + 9'(loss_n);
        if (vs_clr) begin
            drops_d = '0;
            lost_d  = 1'b0;
        end else if (loss_n != '0) begin
            drops_d = drops_sum[8] ? 8'hff : drops_sum[7:0];
            lost_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dr_start_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            dr_start_q <= dr_start_d;
            tmo_q      <= tmo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l_q  <= 1'b0;
            vs_l_q  <= 1'b0;
            drops_q <= '0;
            lost_q  <= 1'b0;
        end else begin
            hs_l_q  <= hs_l_d;
            vs_l_q  <= vs_l_d;
            drops_q <= drops_d;
            lost_q  <= lost_d;
        end
    end

    assign bus.in_busy  = full;
    assign bus.dr_start = dr_start_q;
    assign bus.code     = out_cmd.code;
    assign bus.attr     = out_cmd.attr;
    assign bus.hflip    = out_cmd.hflip;
    assign bus.vflip    = out_cmd.vflip;
    assign bus.hpos     = out_cmd.hpos;
    assign bus.ysub     = out_cmd.ysub;
    assign bus.hzoom    = out_cmd.hzoom;
    assign bus.hz_keep  = out_cmd.hz_keep;
    assign bus.shd      = out_cmd.shd;
    assign drops        = drops_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_jt053246_drawq.sv
// Directed bench for jt053246_drawq: push/dispatch, overflow, flush, timeout, saturation, vs clear, reset.
module tb_jt053246_drawq;
    import jt053246_pkg::*;

    logic       rst, clk, cen, hs, vs;
    logic [3:0] level;
    logic [7:0] drops;
    logic       lost;

    jt053246_drawq_if ifc();

    jt053246_drawq #(.AW(3), .ACK_TO(4)) dut (
        .rst   (rst),
        .clk   (clk),
        .cen   (cen),
        .hs    (hs),
        .vs    (vs),
        .bus   (ifc),
        .level (level),
        .drops (drops),
        .lost  (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] st_code[$];
    int          st_cyc[$];
    int          base;

    // Log every dispatched command with the cycle it was started on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cen && ifc.dr_start) begin
            st_code.push_back(ifc.code);
            st_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] c, input logic [8:0] h);
        ifc.in_start   = 1'b1;
        ifc.in_code    = c;
        ifc.in_hpos    = h;
        ifc.in_attr    = c[9:0] ^ 10'h155;
        ifc.in_hflip   = c[4];
        ifc.in_vflip   = c[0];
        ifc.in_ysub    = c[3:0];
        ifc.in_hzoom   = {c[3:0], 8'h80};
        ifc.in_hz_keep = c[1];
        ifc.in_shd     = c[1:0];
        @(posedge clk);
        #1;
        ifc.in_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; hs = 1'b0; vs = 1'b0;
        ifc.in_start = 1'b0; ifc.in_code = '0; ifc.in_attr = '0; ifc.in_hflip = 1'b0;
        ifc.in_vflip = 1'b0; ifc.in_hpos = '0; ifc.in_ysub = '0; ifc.in_hzoom = '0;
        ifc.in_hz_keep = 1'b0; ifc.in_shd = '0; ifc.dr_busy = 1'b0;
        tick(2);
        chk("rst_level", level, 0);
        chk("rst_dr_start", ifc.dr_start, 0);
        chk("rst_code", ifc.code, 0);
        chk("rst_drops", drops, 0);
        chk("rst_lost", lost, 0);
        chk("rst_in_busy", ifc.in_busy, 0);
        rst = 1'b0;
        tick(1);

        // Single command, drawer acknowledges with busy for 5 cycles.
        base = st_code.size();
        push(16'h1234, 9'h050);
        chk("t1_level_after_push", level, 1);
        tick(1);
        chk("t1_dr_start", ifc.dr_start, 1);
        chk("t1_code", ifc.code, 16'h1234);
        chk("t1_hpos", ifc.hpos, 9'h050);
        chk("t1_attr", ifc.attr, 10'h361);
        chk("t1_hflip", ifc.hflip, 1);
        chk("t1_hzoom", ifc.hzoom, 12'h480);
        chk("t1_level_after_pop", level, 0);
        ifc.dr_busy = 1'b1;
        tick(5);
        ifc.dr_busy = 1'b0;
        tick(3);
        chk("t1_dr_start_low", ifc.dr_start, 0);
        chk("t1_nstarts", st_code.size() - base, 1);
        chk("t1_drops", drops, 0);

        // Fill the queue behind a busy drawer, overflow once, then drain via timeouts.
        ifc.dr_busy = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i), 9'(i));
        chk("t2_level_full", level, 8);
        chk("t2_in_busy", ifc.in_busy, 1);
        push(16'hAAAA, 9'h1ff);
        chk("t2_ovf_drops", drops, 1);
        chk("t2_ovf_lost", lost, 1);
        chk("t2_ovf_level", level, 8);
        base = st_code.size();
        ifc.dr_busy = 1'b0;
        tick(60);
        chk("t2_nstarts", st_code.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("t2_order", st_code[base + i], 16'hA000 + 16'(i));
        chk("t2_timeout_spacing", st_cyc[base + 1] - st_cyc[base], 6);
        chk("t2_level_drained", level, 0);

        vs = 1'b1;
        tick(1);
        vs = 1'b0;
        chk("vs_clear_drops", drops, 0);
        chk("vs_clear_lost", lost, 0);

        // Flush at level 5 while one command is in flight.
        base = st_code.size();
        push(16'hB000, 9'h010);
        tick(1);
        ifc.dr_busy = 1'b1;
        for (int i = 1; i < 6; i++) push(16'hB000 + 16'(i), 9'h010);
        chk("t3_level_pre_flush", level, 5);
        hs = 1'b1;
        tick(1);
        hs = 1'b0;
        chk("t3_flush_level", level, 0);
        chk("t3_flush_drops", drops, 5);
        chk("t3_flush_lost", lost, 1);
        ifc.dr_busy = 1'b0;
        tick(10);
        chk("t3_nstarts", st_code.size() - base, 1);
        chk("t3_inflight_code", st_code[base], 16'hB000);

        // Push and pop in the same cycle at level 3.
        ifc.dr_busy = 1'b1;
        base = st_code.size();
        push(16'hC000, 9'h020);
        push(16'hC001, 9'h020);
        push(16'hC002, 9'h020);
        chk("t4_level3", level, 3);
        ifc.dr_busy = 1'b0;
        push(16'hC003, 9'h020);
        chk("t4_level_same", level, 3);
        chk("t4_oldest_code", ifc.code, 16'hC000);
        chk("t4_dr_start", ifc.dr_start, 1);
        tick(40);
        chk("t4_nstarts", st_code.size() - base, 4);
        chk("t4_last_code", st_code[base + 3], 16'hC003);
        chk("t4_level_drained", level, 0);

        // Saturating drop counter, vs-wins-over-loss, cen gating of hs.
        vs = 1'b1;
        tick(1);
        vs = 1'b0;
        chk("t6_vs_drops", drops, 0);
        ifc.dr_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(16'hE000 + 16'(i), 9'h0);
        for (int i = 0; i < 200; i++) push(16'hEEEE, 9'h0);
        chk("t6_drops200", drops, 200);
        chk("t6_lost", lost, 1);
        chk("t6_level", level, 8);
        for (int i = 0; i < 100; i++) push(16'hEEEE, 9'h0);
        chk("t6_drops_sat", drops, 255);
        vs = 1'b1;
        push(16'hEEEE, 9'h0);
        vs = 1'b0;
        chk("t6_vs_wins_drops", drops, 0);
        chk("t6_vs_wins_lost", lost, 0);
        cen = 1'b0;
        hs = 1'b1;
        ifc.in_start = 1'b1;
        tick(1);
        ifc.in_start = 1'b0;
        chk("t6_cen0_level", level, 8);
        chk("t6_cen0_drops", drops, 0);
        cen = 1'b1;
        tick(1);
        hs = 1'b0;
        chk("t6_late_flush_level", level, 0);
        chk("t6_late_flush_drops", drops, 8);
        chk("t6_late_flush_lost", lost, 1);

        // Asynchronous reset while the dispatcher waits in DONE.
        ifc.dr_busy = 1'b0;
        push(16'hD000, 9'h030);
        push(16'hD001, 9'h031);
        ifc.dr_busy = 1'b1;
        tick(3);
        chk("t7_level_pre_rst", level, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_dr_start", ifc.dr_start, 0);
        chk("t7_rst_code", ifc.code, 0);
        chk("t7_rst_hpos", ifc.hpos, 0);
        chk("t7_rst_level", level, 0);
        chk("t7_rst_drops", drops, 0);
        chk("t7_rst_lost", lost, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.dr_busy = 1'b0;
        base = st_code.size();
        tick(10);
        chk("t7_no_starts_after_rst", st_code.size() - base, 0);
        chk("t7_level_after_rst", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
